tmds_channel_encoder: RTL and testbench



---
 rtl/tmds_pkg.sv | 21 ++
 rtl/tmds_qm_stage.sv | 31 +++
 rtl/tmds_channel_encoder.sv | 99 +++++++++
 tb/tb_tmds_channel_encoder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared constants and helpers for the TMDS channel encoder.
package tmds_pkg;

    // 10-bit control-period codes, indexed by {c1,c0}
    localparam logic [9:0] CTL00        = 10'b1101010100;
    localparam logic [9:0] CTL01        = 10'b0010101011;
    localparam logic [9:0] CTL10        = 10'b0101010100;
    localparam logic [9:0] CTL11        = 10'b1010101011;
    localparam logic [9:0] RESET_SYMBOL = CTL00;

    // Number of ones in an 8-bit word
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// Stage-1 transition minimisation: 8-bit pixel -> 9-bit q_m word.
// q_m[8] records which chain was used (1 = XOR, 0 = XNOR).
module tmds_qm_stage
    import tmds_pkg::*;
(
    input  logic [7:0] data,
    output logic [8:0] q_m
);

    function automatic logic [8:0] minimise(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] q;
        n1       = popcount8(d);
        // XNOR chain when it yields fewer transitions
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = 9'd0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    // Purely combinational; the top registers the result
    always_comb begin
        q_m = minimise(data);
    end

endmodule

// File: rtl/tmds_channel_encoder.sv
// One DVI/TMDS channel: 8b pixel or 2b control -> 10b DC-balanced symbol.
// Two register stages: q_m/blank/ctl, then symbol and running disparity.
module tmds_channel_encoder
    import tmds_pkg::*;
#(
    parameter int DISP_W = 5
)
(
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     blank,
    input  logic [1:0]               ctl,
    input  logic [7:0]               data,
    output logic [9:0]               symbol,
    output logic signed [DISP_W-1:0] disp
);

    localparam logic signed [DISP_W-1:0] ZERO = '0;
    localparam logic signed [DISP_W-1:0] TWO  = DISP_W'(2);
    localparam logic signed [DISP_W-1:0] EIGHT = DISP_W'(8);

    logic [8:0]               q_m_p0;
    logic [8:0]               q_m_p1;
    logic                     blank_p1;
    logic [1:0]               ctl_p1;
    logic [9:0]               symbol_p2;
    logic signed [DISP_W-1:0] cnt_p2;

    logic [3:0]               n1_p1;
    logic signed [DISP_W-1:0] diff_p1;
    logic                     cnt_pos;
    logic                     cnt_neg;
    logic                     q8;
    logic [9:0]               symbol_nxt;
    logic signed [DISP_W-1:0] cnt_nxt;

    tmds_qm_stage u_qm (
        .data (data),
        .q_m  (q_m_p0)
    );

    // Stage 1 boundary: capture q_m with its blank/ctl; reset looks like a ctl-00 period
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_m_p1   <= 9'd0;
            blank_p1 <= 1'b1;
            ctl_p1   <= 2'b00;
        end else begin
            q_m_p1   <= q_m_p0;
            blank_p1 <= blank;
            ctl_p1   <= ctl;
        end
    end

    // DC balance: choose inversion from the current disparity and q_m weight
    always_comb begin
        n1_p1      = popcount8(q_m_p1[7:0]);
        // n1 - n0 = 2*n1 - 8
        diff_p1    = DISP_W'({n1_p1, 1'b0}) - EIGHT;
        q8         = q_m_p1[8];
        cnt_pos    = !cnt_p2[DISP_W-1] && (cnt_p2 != ZERO);
        cnt_neg    = cnt_p2[DISP_W-1];
        symbol_nxt = RESET_SYMBOL;
        cnt_nxt    = ZERO;
        if (blank_p1) begin
            case (ctl_p1)
                2'b00:   symbol_nxt = CTL00;
                2'b01:   symbol_nxt = CTL01;
                2'b10:   symbol_nxt = CTL10;
                default: symbol_nxt = CTL11;
            endcase
            cnt_nxt = ZERO;
        end else if ((cnt_p2 == ZERO) || (n1_p1 == 4'd4)) begin
            symbol_nxt = {~q8, q8, q8 ? q_m_p1[7:0] : ~q_m_p1[7:0]};
            cnt_nxt    = q8 ? (cnt_p2 + diff_p1) : (cnt_p2 - diff_p1);
        end else if ((cnt_pos && (n1_p1 > 4'd4)) || (cnt_neg && (n1_p1 < 4'd4))) begin
            symbol_nxt = {1'b1, q8, ~q_m_p1[7:0]};
            cnt_nxt    = cnt_p2 - diff_p1 + (q8 ? TWO : ZERO);
        end else begin
            symbol_nxt = {1'b0, q8, q_m_p1[7:0]};
            cnt_nxt    = cnt_p2 + diff_p1 - (q8 ? ZERO : TWO);
        end
    end

    // Stage 2 boundary: registered symbol and running disparity
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            symbol_p2 <= RESET_SYMBOL;
            cnt_p2    <= ZERO;
        end else begin
            symbol_p2 <= symbol_nxt;
            cnt_p2    <= cnt_nxt;
        end
    end

    assign symbol = symbol_p2;
    assign disp   = cnt_p2;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Self-checking bench for tmds_channel_encoder against a behavioural TMDS model.
module tb_tmds_channel_encoder;
    import tmds_pkg::*;

    localparam int DISP_W = 5;

    logic                     clock = 1'b0;
    logic                     reset_n = 1'b1;
    logic                     blank = 1'b1;
    logic [1:0]               ctl = 2'b00;
    logic [7:0]               data = 8'h00;
    logic [9:0]               symbol;
    logic signed [DISP_W-1:0] disp;

    typedef struct {
        logic [9:0] sym;
        int         dsp;
        bit         act;
        logic [7:0] dat;
    } exp_t;

    exp_t pipe[$];
    int   ref_cnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    tmds_channel_encoder #(.DISP_W(DISP_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .blank   (blank),
        .ctl     (ctl),
        .data    (data),
        .symbol  (symbol),
        .disp    (disp)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", tag, got, got, want, want, $time);
        end
    endtask

    // Reference: transition-minimise, decide inversion, then disparity = ones - zeros of the sent symbol
    function automatic exp_t ref_encode(input bit b, input logic [1:0] c, input logic [7:0] d);
        exp_t       e;
        logic [7:0] q;
        bit         q8;
        bit         xn;
        bit         inv;
        int         ones;
        int         zeros;
        e.act = !b;
        e.dat = d;
        if (b) begin
            case (c)
                2'b00:   e.sym = 10'h354;
                2'b01:   e.sym = 10'h0AB;
                2'b10:   e.sym = 10'h154;
                default: e.sym = 10'h2AB;
            endcase
            ref_cnt = 0;
        end else begin
            xn   = ($countones(d) > 4) || ($countones(d) == 4 && d[0] == 1'b0);
            q[0] = d[0];
            for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
            q8    = !xn;
            ones  = $countones(q);
            zeros = 8 - ones;
            if (ref_cnt == 0 || ones == zeros)                                  inv = !q8;
            else if ((ref_cnt > 0 && ones > zeros) || (ref_cnt < 0 && zeros > ones)) inv = 1'b1;
            else                                                                 inv = 1'b0;
            e.sym   = {inv, q8, inv ? ~q : q};
            ref_cnt = ref_cnt + 2 * $countones(e.sym) - 10;
        end
        e.dsp = ref_cnt;
        return e;
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] d;
        q    = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    // One clock: drive inputs, then compare the symbol due two cycles after its inputs
    task automatic cycle(input bit b, input logic [1:0] c, input logic [7:0] d);
        exp_t e;
        blank = b;
        ctl   = c;
        data  = d;
        pipe.push_back(ref_encode(b, c, d));
        @(posedge clock);
        #1;
        if (pipe.size() >= 2) begin
            e = pipe.pop_front();
            check("symbol", {22'd0, symbol}, {22'd0, e.sym});
            check("disp", $signed(disp), e.dsp);
            check("disp_bound", ($signed(disp) <= 10 && $signed(disp) >= -10) ? 1 : 0, 1);
            if (e.act) check("decode", {24'd0, decode(symbol)}, {24'd0, e.dat});
        end
    endtask

    task automatic assert_reset();
        reset_n = 1'b0;
        blank   = 1'b1;
        ctl     = 2'b00;
        data    = 8'h00;
        #1;
        check("rst_symbol", {22'd0, symbol}, {22'd0, 10'h354});
        check("rst_disp", $signed(disp), 0);
    endtask

    task automatic release_reset();
        exp_t e;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        ref_cnt = 0;
        pipe.delete();
        e.sym = 10'h354;
        e.dsp = 0;
        e.act = 1'b0;
        e.dat = 8'h00;
        pipe.push_back(e);
    endtask

    initial begin
        int active;
        #2;
        assert_reset();
        release_reset();

        // Control codes
        for (int c = 0; c < 4; c++) cycle(1'b1, 2'(c), 8'h00);
        cycle(1'b1, 2'b00, 8'h00);

        // Zero pixels after blanking, then all-ones from cnt=0
        cycle(1'b0, 2'b00, 8'h00);
        cycle(1'b0, 2'b00, 8'h00);
        cycle(1'b1, 2'b00, 8'h00);
        cycle(1'b0, 2'b00, 8'hFF);
        cycle(1'b1, 2'b00, 8'h00);

        // Random active video with occasional blanking
        active = 0;
        while (active < 10000) begin
            if ($urandom_range(31) == 0) begin
                cycle(1'b1, 2'($urandom_range(3)), 8'($urandom));
            end else begin
                cycle(1'b0, 2'($urandom_range(3)), 8'($urandom));
                active++;
            end
        end

        // Mid-stream asynchronous reset with nonzero disparity
        cycle(1'b1, 2'b00, 8'h00);
        cycle(1'b0, 2'b00, 8'h00);
        cycle(1'b0, 2'b00, 8'h00);
        check("pre_rst_disp_nonzero", ($signed(disp) != 0) ? 1 : 0, 1);
        #2;
        assert_reset();
        release_reset();
        cycle(1'b0, 2'b00, 8'h00);
        cycle(1'b0, 2'b00, 8'h00);
        cycle(1'b0, 2'b00, 8'hA5);

        // Alternate blank every cycle
        for (int i = 0; i < 40; i++) cycle(1'(i % 2), 2'($urandom_range(3)), 8'($urandom));

        cycle(1'b1, 2'b00, 8'h00);
        cycle(1'b1, 2'b00, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
